// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_perf_ctr.sv
// Fetch performance counters: consumed instructions, stalled cycles, flushes.
module fetch_perf_ctr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_evt,
  input  logic        stall_evt,
  input  logic        flush_evt,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (fetch_evt) fetch_cnt <= fetch_cnt + 32'd1;
      if (stall_evt) stall_cnt <= stall_cnt + 32'd1;
      if (flush_evt) flush_cnt <= flush_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, imem handshake, one-entry hold
// buffer and redirect draining. Optional counters under FETCH_PERF_EN.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  fetch_addr;
  logic [31:0]  hold_pc;
  logic [31:0]  hold_instr;
  logic         consumed;
  logic         slot_free;
  logic [31:0]  redirect_target;

  assign consumed        = if_valid && !stall;
  assign slot_free       = !if_valid || !stall;
  assign redirect_target = word_align(redirect_addr);
  assign imem_addr       = fetch_addr;

  // NOTE: all state uses non-blocking assignments so every register sees
  // pre-edge values regardless of statement order within the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pc         <= word_align(RESET_PC);
      fetch_addr <= word_align(RESET_PC);
      hold_pc    <= '0;
      hold_instr <= '0;
      if_valid   <= 1'b0;
      if_pc      <= '0;
      if_instr   <= '0;
      imem_req   <= 1'b0;
    end else begin
      if (consumed) if_valid <= 1'b0;

      if (redirect_valid) begin
        // Redirect overrides stall and ack; output and hold contents are dropped.
        if_valid <= 1'b0;
        pc       <= redirect_target;
        imem_req <= 1'b1;
        if (state == ST_IDLE || state == ST_HOLD || imem_ack) begin
          fetch_addr <= redirect_target;
          state      <= ST_FETCH;
        end else begin
          // Outstanding request must complete at its original address.
          state <= ST_DRAIN;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            fetch_addr <= pc;
            imem_req   <= 1'b1;
            state      <= ST_FETCH;
          end
          ST_FETCH: begin
            if (imem_ack) begin
              pc         <= pc + PC_STEP;
              fetch_addr <= fetch_addr + PC_STEP;
              if (slot_free) begin
                if_valid <= 1'b1;
                if_pc    <= fetch_addr;
                if_instr <= imem_rdata;
              end else begin
                hold_pc    <= fetch_addr;
                hold_instr <= imem_rdata;
                imem_req   <= 1'b0;
                state      <= ST_HOLD;
              end
            end
          end
          ST_HOLD: begin
            if (slot_free) begin
              if_valid <= 1'b1;
              if_pc    <= hold_pc;
              if_instr <= hold_instr;
              imem_req <= 1'b1;
              state    <= ST_FETCH;
            end
          end
          ST_DRAIN: begin
            if (imem_ack) begin
              fetch_addr <= pc;
              state      <= ST_FETCH;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef FETCH_PERF_EN
  fetch_perf_ctr u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_evt (consumed),
    .stall_evt (if_valid && stall),
    .flush_evt (redirect_valid),
    .fetch_cnt (perf_fetch_cnt),
    .stall_cnt (perf_stall_cnt),
    .flush_cnt (perf_flush_cnt)
  );
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl; memory returns addr ^ INSTR_KEY.
module tb_fetch_ctrl;

  localparam logic [31:0] INSTR_KEY = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b1;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  int errors = 0;
  int checks = 0;

  assign imem_rdata = imem_addr ^ INSTR_KEY;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    stall = 1'b0;
    imem_ack = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_ack = 1'b1;
    tick();
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", if_valid); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_if_pc: got %h exp 0", if_pc); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_if_instr: got %h exp 0", if_instr); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL rst_addr: got %h exp 100", imem_addr); end
    checks++; if (perf_fetch_cnt !== 32'h0) begin errors++; $display("FAIL rst_perf_fetch: got %0d exp 0", perf_fetch_cnt); end
    checks++; if (perf_stall_cnt !== 32'h0) begin errors++; $display("FAIL rst_perf_stall: got %0d exp 0", perf_stall_cnt); end
    checks++; if (perf_flush_cnt !== 32'h0) begin errors++; $display("FAIL rst_perf_flush: got %0d exp 0", perf_flush_cnt); end
    rst_n = 1'b1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b exp 0", imem_req); end
  endtask

  task automatic test_stream();
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL stream_first: req %b addr %h exp 1 100", imem_req, imem_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid: got %b exp 0", if_valid); end
    tick();
    checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL stream_addr104: got %h exp 104", imem_addr); end
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin errors++; $display("FAIL stream_pc100: valid %b pc %h exp 1 100", if_valid, if_pc); end
    checks++; if (if_instr !== (32'h100 ^ INSTR_KEY)) begin errors++; $display("FAIL stream_instr100: got %h exp %h", if_instr, 32'h100 ^ INSTR_KEY); end
    tick();
    checks++; if (imem_addr !== 32'h108 || if_pc !== 32'h104) begin errors++; $display("FAIL stream_108: addr %h pc %h exp 108 104", imem_addr, if_pc); end
  endtask

  task automatic test_reset_abort();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL abort_pre_req: got %b exp 1", imem_req); end
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL abort_req_drop: got %b exp 0", imem_req); end
    checks++; if (imem_addr !== 32'h100 || if_valid !== 1'b0) begin errors++; $display("FAIL abort_state: addr %h valid %b exp 100 0", imem_addr, if_valid); end
  endtask

  task automatic test_stall();
    restart();
    tick();
    tick();
    stall = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req1: got %b exp 0", imem_req); end
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin errors++; $display("FAIL stall_hold_out: valid %b pc %h exp 1 100", if_valid, if_pc); end
    tick();
    tick();
    checks++; if (imem_req !== 1'b0 || if_pc !== 32'h100) begin errors++; $display("FAIL stall_req3: req %b pc %h exp 0 100", imem_req, if_pc); end
    stall = 1'b0;
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h104) begin errors++; $display("FAIL stall_release_pc: valid %b pc %h exp 1 104", if_valid, if_pc); end
    checks++; if (if_instr !== (32'h104 ^ INSTR_KEY)) begin errors++; $display("FAIL stall_release_instr: got %h exp %h", if_instr, 32'h104 ^ INSTR_KEY); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h108) begin errors++; $display("FAIL stall_resume_req: req %b addr %h exp 1 108", imem_req, imem_addr); end
    tick();
    checks++; if (if_pc !== 32'h108 || imem_addr !== 32'h10C) begin errors++; $display("FAIL stall_next: pc %h addr %h exp 108 10c", if_pc, imem_addr); end
  endtask

  task automatic test_redirect_ack();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h2002;
    tick();
    redirect_valid = 1'b0;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got %b exp 0", if_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin errors++; $display("FAIL redir_addr: req %b addr %h exp 1 2000", imem_req, imem_addr); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h2000) begin errors++; $display("FAIL redir_pc: valid %b pc %h exp 1 2000", if_valid, if_pc); end
    checks++; if (if_instr !== (32'h2000 ^ INSTR_KEY)) begin errors++; $display("FAIL redir_instr: got %h exp %h", if_instr, 32'h2000 ^ INSTR_KEY); end
  endtask

  task automatic test_drain();
    restart();
    tick();
    tick();
    tick();
    tick();
    checks++; if (imem_addr !== 32'h10C) begin errors++; $display("FAIL drain_setup: got %h exp 10c", imem_addr); end
    imem_ack       = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr  = 32'h300;
    tick();
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10C || if_valid !== 1'b0) begin errors++; $display("FAIL drain_c1: req %b addr %h valid %b exp 1 10c 0", imem_req, imem_addr, if_valid); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10C || if_valid !== 1'b0) begin errors++; $display("FAIL drain_c2: req %b addr %h valid %b exp 1 10c 0", imem_req, imem_addr, if_valid); end
    imem_ack = 1'b1;
    tick();
    checks++; if (imem_addr !== 32'h300 || if_valid !== 1'b0) begin errors++; $display("FAIL drain_done: addr %h valid %b exp 300 0", imem_addr, if_valid); end
    tick();
    checks++; if (if_pc !== 32'h300 || if_instr !== (32'h300 ^ INSTR_KEY)) begin errors++; $display("FAIL drain_out: pc %h instr %h exp 300 %h", if_pc, if_instr, 32'h300 ^ INSTR_KEY); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_addr  = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top: got %h exp fffffffc", imem_addr); end
    tick();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h exp 0", imem_addr); end
    checks++; if (if_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %h exp fffffffc", if_pc); end
  endtask

  task automatic test_redirect_idle_hold();
    restart();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h500;
    tick();
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h500) begin errors++; $display("FAIL idle_redir: req %b addr %h exp 1 500", imem_req, imem_addr); end
    tick();
    checks++; if (if_pc !== 32'h500) begin errors++; $display("FAIL idle_redir_pc: got %h exp 500", if_pc); end
    stall = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h400;
    tick();
    redirect_valid = 1'b0;
    stall = 1'b0;
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h400) begin errors++; $display("FAIL hold_redir: valid %b req %b addr %h exp 0 1 400", if_valid, imem_req, imem_addr); end
    tick();
    checks++; if (if_pc !== 32'h400 || if_instr !== (32'h400 ^ INSTR_KEY)) begin errors++; $display("FAIL hold_redir_out: pc %h instr %h exp 400 %h", if_pc, if_instr, 32'h400 ^ INSTR_KEY); end
  endtask

  task automatic test_perf();
    logic [31:0] exp_fetch;
    logic [31:0] exp_stall;
    logic [31:0] exp_flush;
`ifdef FETCH_PERF_EN
    exp_fetch = 32'd10;
    exp_stall = 32'd4;
    exp_flush = 32'd2;
`else
    exp_fetch = 32'd0;
    exp_stall = 32'd0;
    exp_flush = 32'd0;
`endif
    restart();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h600;
    tick();
    redirect_addr  = 32'h700;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    stall = 1'b0;
    tick();
    checks++; if (perf_fetch_cnt !== exp_fetch) begin errors++; $display("FAIL perf_fetch: got %0d exp %0d", perf_fetch_cnt, exp_fetch); end
    checks++; if (perf_stall_cnt !== exp_stall) begin errors++; $display("FAIL perf_stall: got %0d exp %0d", perf_stall_cnt, exp_stall); end
    checks++; if (perf_flush_cnt !== exp_flush) begin errors++; $display("FAIL perf_flush: got %0d exp %0d", perf_flush_cnt, exp_flush); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_reset_abort();
    test_stall();
    test_redirect_ack();
    test_drain();
    test_wrap();
    test_redirect_idle_hold();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
